// File: rtl/counted_stack_if.sv
// counted_stack_if: command/status bundle for counted_stack.
//   master: drives push, pop, insert, err_clear; observes the stack state.
//   slave : the stack itself; drives top, second, count, empty, full,
//           overflow, underflow.
// WIDTH/DEPTH must match the counted_stack instance attached to it.
interface counted_stack_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic             push;
  logic             pop;
  logic [WIDTH-1:0] insert;
  logic             err_clear;
  logic [WIDTH-1:0] top;
  logic [WIDTH-1:0] second;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop, insert, err_clear,
    input  top, second, count, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, insert, err_clear,
    output top, second, count, empty, full, overflow, underflow
  );
endinterface

// File: rtl/counted_stack.sv
// counted_stack: register-array LIFO with occupancy count.
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears contents, count and flags
//   bus        counted_stack_if.slave
//     push/pop/insert  stack commands (push+pop together replaces the top)
//     err_clear        clears sticky overflow/underflow (a new event wins)
//     top/second       elements 0 and 1, registered
//     count            valid elements 0..DEPTH; empty/full follow it
//     overflow         sticky: a push on a full stack lost the bottom element
//     underflow        sticky: a pop found the stack empty
// Build option: define COUNTED_STACK_ERR_EN to enable overflow/underflow
// tracking; otherwise both flags read 0 and err_clear is ignored.
module counted_stack #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8
) (
  input logic          clk,
  input logic          reset,
  counted_stack_if.slave bus
);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  // Element 0 sits in the low WIDTH bits so shifts are plain concatenations.
  logic [DEPTH-1:0][WIDTH-1:0] elem_q, elem_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        empty_q, full_q;
  logic                        ovf_q, ovf_d, unf_q, unf_d;
  logic                        ovf_ev, unf_ev;
  logic                        is_empty, is_full;

  assign is_empty = (cnt_q == CW'(0));
  assign is_full  = (cnt_q == CW'(DEPTH));

  // Next-state for the element array, count and error events.
  always_comb begin
    elem_d = elem_q;
    cnt_d  = cnt_q;
    ovf_ev = 1'b0;
    unf_ev = 1'b0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        // Bottom element falls off when full; count saturates at DEPTH.
        elem_d = {elem_q[DEPTH-2:0], bus.insert};
        if (is_full) ovf_ev = 1'b1;
        else         cnt_d  = cnt_q + CW'(1);
      end
      2'b01: begin
        if (is_empty) begin
          unf_ev = 1'b1;
        end else begin
          // Zero-fill keeps elements beyond count reading as zero.
          elem_d = {{WIDTH{1'b0}}, elem_q[DEPTH-1:1]};
          cnt_d  = cnt_q - CW'(1);
        end
      end
      2'b11: begin
        elem_d[0] = bus.insert;
        if (is_empty) begin
          unf_ev = 1'b1;
          cnt_d  = CW'(1);
        end
      end
      default: ;
    endcase
  end

  // Sticky error flags; a same-cycle event beats err_clear.
`ifdef COUNTED_STACK_ERR_EN
  always_comb begin
    ovf_d = ovf_ev | (ovf_q & ~bus.err_clear);
    unf_d = unf_ev | (unf_q & ~bus.err_clear);
  end
`else
  logic unused_err;
  assign unused_err = ^{bus.err_clear, ovf_ev, unf_ev};
  always_comb begin
    ovf_d = 1'b0;
    unf_d = 1'b0;
  end
`endif

  // State register; empty/full are registered from the next count.
  always_ff @(posedge clk) begin
    if (reset) begin
      elem_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      elem_q  <= elem_d;
      cnt_q   <= cnt_d;
      empty_q <= (cnt_d == CW'(0));
      full_q  <= (cnt_d == CW'(DEPTH));
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.top       = elem_q[0];
  assign bus.second    = elem_q[1];
  assign bus.count     = cnt_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
endmodule

// File: doc/counted_stack.md
COUNTED_STACK -- requirements
Module: counted_stack

Interface
REQ-001 SHALL have parameter WIDTH, default 32: bit width of each stack element.
REQ-002 SHALL have parameter DEPTH, default 8: number of elements; legal range 2..256.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-high reset.
REQ-005 SHALL have port push  input  1: push insert onto the stack this cycle.
REQ-006 SHALL have port pop  input  1: discard top element this cycle.
REQ-007 SHALL have port insert  input  WIDTH: value written on push.
REQ-008 SHALL have port err_clear  input  1: clears sticky error flags.
REQ-009 SHALL have port top  output  WIDTH: element 0, registered.
REQ-010 SHALL have port second  output  WIDTH: element 1, registered.
REQ-011 SHALL have port count  output  $clog2(DEPTH+1): number of valid elements, 0..DEPTH.
REQ-012 SHALL have port empty  output  1: count == 0.
REQ-013 SHALL have port full  output  1: count == DEPTH.
REQ-014 SHALL have port overflow  output  1: sticky, a push lost the bottom element.
REQ-015 SHALL have port underflow  output  1: sticky, a pop hit an empty stack.

Function
REQ-016 SHALL keep elements e[0..DEPTH-1] in a register shift array; top=e[0], second=e[1]; empty/full decoded combinationally from count.
REQ-017 Push only: e[i]<=e[i-1] for i>=1, e[0]<=insert; count+1; top shows insert on the cycle after the edge (1-cycle latency).
REQ-018 Push only while full: shift still occurs, old e[DEPTH-1] discarded, count stays DEPTH, overflow<=1.
REQ-019 Pop only: e[i]<=e[i+1] for i<DEPTH-1, e[DEPTH-1]<=0; count-1.
REQ-020 Pop only while empty: elements and count unchanged, underflow<=1.
REQ-021 Push and pop same cycle: e[0]<=insert, e[1..DEPTH-1] unchanged, count unchanged (replace-top).
REQ-022 Push and pop while empty: e[0]<=insert, count<=1, underflow<=1.
REQ-023 Neither asserted: all state holds.
REQ-024 err_clear clears overflow and underflow; if a new error event occurs in the same cycle, the set wins.
REQ-025 Elements at index >= count SHALL read as zero (guaranteed by zero-fill on pop and reset).

Reset
REQ-026 On reset=1 at a clock edge: all e[i]<=0, count<=0, overflow<=0, underflow<=0; push/pop/err_clear ignored that cycle.
REQ-027 After reset: top=0, second=0, count=0, empty=1, full=0; reset mid-operation discards all contents.

Configuration
REQ-028 Macro COUNTED_STACK_ERR_EN SHALL gate error tracking.
REQ-029 With COUNTED_STACK_ERR_EN defined: overflow/underflow/err_clear behave per REQ-018..REQ-024.
REQ-030 Without it: overflow and underflow tied 0, err_clear ignored; data/count behaviour identical, including bottom discard on full push.

Verification (WIDTH=8, DEPTH=4)
REQ-031 Reset, then push 0x11,0x22,0x33,0x44 -> top=0x44, second=0x33, count=4, full=1, overflow=0.
REQ-032 From REQ-031 state, push 0x55 -> top=0x55, count=4, overflow=1; then pop x4 -> tops 0x44,0x33,0x22,0x00 with empty=1 (0x11 lost).
REQ-033 From empty, pop -> count=0, top=0x00, underflow=1; err_clear -> underflow=0 next cycle.
REQ-034 Push 0xA1, 0xB2, then push+pop with insert 0xC3 -> top=0xC3, second=0xA1, count=2.
REQ-035 Push 0x7E x3, assert reset together with push -> top=0, count=0, empty=1, flags 0.
REQ-036 Build without COUNTED_STACK_ERR_EN, repeat REQ-032 and REQ-033 -> identical data and count, overflow=underflow=0 throughout.
